traffic_phase_scheduler: RTL and testbench

- Sequences the four-lane intersection between two conflicting phases: NS (lanes 0, 2) and EW (lanes 1, 3).
- Runs a timed green/yellow/all-red cycle gated by car-sensor requests, and enters a flashing night mode on demand.
- Sits above the per-lane light drivers and owns the 8-bit `laneOutput` bus that feeds them.

---
 rtl/traffic_phase_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler
// Two-phase (NS = lanes 0/2, EW = lanes 1/3) intersection sequencer with
// tick-timed green / yellow / all-red intervals, sensor-driven phase changes
// and a flashing night mode. Drives the 8-bit lane light-code bus.
module traffic_phase_scheduler #(
  parameter int GREEN_TICKS  = 4,
  parameter int YELLOW_TICKS = 2,
  parameter int ALLRED_TICKS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [3:0] req,
  input  logic       night,
  output logic [7:0] laneOutput,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_1  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_2  = 3'd5,
    NIGHT     = 3'd6
  } state_t;

  // Last counter value of each timed interval (counter starts at 0 on entry).
  localparam logic [7:0] GREEN_LAST  = 8'(GREEN_TICKS - 1);
  localparam logic [7:0] YELLOW_LAST = 8'(YELLOW_TICKS - 1);
  localparam logic [7:0] ALLRED_LAST = 8'(ALLRED_TICKS - 1);

  localparam logic [1:0] CODE_RED    = 2'b00;
  localparam logic [1:0] CODE_GREEN  = 2'b01;
  localparam logic [1:0] CODE_YELLOW = 2'b10;
  localparam logic [1:0] CODE_DARK   = 2'b11;

  // Places the NS code on lanes 0/2 and the EW code on lanes 1/3.
  function automatic logic [7:0] pack_lanes(input logic [1:0] ns_code,
                                            input logic [1:0] ew_code);
    return {ew_code, ns_code, ew_code, ns_code};
  endfunction

  state_t     state_r, state_s;
  logic [7:0] cnt_r, cnt_s;
  logic       pend_ns_r, pend_ns_s;
  logic       pend_ew_r, pend_ew_s;
  logic       flash_r, flash_s;
  logic       enter_ns_s, enter_ew_s;
  logic [7:0] lane_s;

  // State, interval counter, pending flags and flash bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ALLRED_2;
      cnt_r     <= 8'd0;
      pend_ns_r <= 1'b0;
      pend_ew_r <= 1'b0;
      flash_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      pend_ns_r <= pend_ns_s;
      pend_ew_r <= pend_ew_s;
      flash_r   <= flash_s;
    end
  end

  // Next-state logic: everything advances only on tick cycles.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    flash_s = flash_r;
    if (tick) begin
      case (state_r)
        NS_GREEN: begin
          if (cnt_r < GREEN_LAST) begin
            cnt_s = cnt_r + 8'd1;
          end else if (pend_ew_r || night) begin
            state_s = NS_YELLOW;
            cnt_s   = 8'd0;
          end else begin
            cnt_s = cnt_r;  // rest in green, counter saturated
          end
        end
        EW_GREEN: begin
          if (cnt_r < GREEN_LAST) begin
            cnt_s = cnt_r + 8'd1;
          end else if (pend_ns_r || night) begin
            state_s = EW_YELLOW;
            cnt_s   = 8'd0;
          end else begin
            cnt_s = cnt_r;
          end
        end
        NS_YELLOW, EW_YELLOW: begin
          if (cnt_r == YELLOW_LAST) begin
            state_s = (state_r == NS_YELLOW) ? ALLRED_1 : ALLRED_2;
            cnt_s   = 8'd0;
          end else begin
            cnt_s = cnt_r + 8'd1;
          end
        end
        ALLRED_1, ALLRED_2: begin
          if (cnt_r == ALLRED_LAST) begin
            cnt_s = 8'd0;
            if (night) begin
              state_s = NIGHT;
            end else if (state_r == ALLRED_1) begin
              state_s = EW_GREEN;
            end else begin
              state_s = NS_GREEN;
            end
          end else begin
            cnt_s = cnt_r + 8'd1;
          end
        end
        NIGHT: begin
          if (night) begin
            flash_s = ~flash_r;
          end else begin
            state_s = ALLRED_2;
            cnt_s   = 8'd0;
            flash_s = 1'b0;
          end
        end
        default: begin
          // Unreachable encoding: recover to the safe all-red state.
          state_s = ALLRED_2;
          cnt_s   = 8'd0;
          flash_s = 1'b0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Pending requests: set by sensors on any clk, cleared when entering the
  // matching green (clear has priority), and suppressed entirely in NIGHT.
  always_comb begin
    enter_ns_s = (state_s == NS_GREEN) && (state_r != NS_GREEN);
    enter_ew_s = (state_s == EW_GREEN) && (state_r != EW_GREEN);
    if (state_r == NIGHT) begin
      pend_ns_s = 1'b0;
      pend_ew_s = 1'b0;
    end else begin
      if (enter_ns_s) begin
        pend_ns_s = 1'b0;
      end else begin
        pend_ns_s = pend_ns_r | req[0] | req[2];
      end
      if (enter_ew_s) begin
        pend_ew_s = 1'b0;
      end else begin
        pend_ew_s = pend_ew_r | req[1] | req[3];
      end
    end
  end

  // Light-code decode from the registered state; never lights both phases.
  always_comb begin
    lane_s = pack_lanes(CODE_RED, CODE_RED);
    case (state_r)
      NS_GREEN:  lane_s = pack_lanes(CODE_GREEN, CODE_RED);
      NS_YELLOW: lane_s = pack_lanes(CODE_YELLOW, CODE_RED);
      EW_GREEN:  lane_s = pack_lanes(CODE_RED, CODE_GREEN);
      EW_YELLOW: lane_s = pack_lanes(CODE_RED, CODE_YELLOW);
      ALLRED_1, ALLRED_2: lane_s = pack_lanes(CODE_RED, CODE_RED);
      NIGHT: begin
        if (flash_r) begin
          lane_s = pack_lanes(CODE_DARK, CODE_DARK);
        end else begin
          lane_s = pack_lanes(CODE_YELLOW, CODE_RED);
        end
      end
      default: lane_s = pack_lanes(CODE_RED, CODE_RED);
    endcase
  end

  assign laneOutput = lane_s;
  assign phase      = state_r;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Self-checking bench for traffic_phase_scheduler (default parameters).
// A behavioural model tracks phase, elapsed ticks and pending requests and
// predicts the light bus; directed scenarios also use literal expectations.
module tb_traffic_phase_scheduler;

  localparam int GREEN  = 4;
  localparam int YELLOW = 2;
  localparam int ALLRED = 1;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic [3:0] req;
  logic       night;
  logic [7:0] laneOutput;
  logic [2:0] phase;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int   m_phase;   // 0 NSG,1 NSY,2 AR1,3 EWG,4 EWY,5 AR2,6 NIGHT
  int   m_time;    // ticks already spent in the current phase
  logic m_pns, m_pew, m_flash;

  traffic_phase_scheduler #(
    .GREEN_TICKS(GREEN), .YELLOW_TICKS(YELLOW), .ALLRED_TICKS(ALLRED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .req(req), .night(night),
    .laneOutput(laneOutput), .phase(phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_phase = 5; m_time = 0; m_pns = 1'b0; m_pew = 1'b0; m_flash = 1'b0;
  endtask

  // Advance the model by one clk edge using the inputs present before it.
  task automatic model_edge(input logic t, input logic [3:0] r, input logic n);
    int nxt;
    int nt;
    logic nf;
    logic opp;
    nxt = m_phase; nt = m_time; nf = m_flash;
    if (t) begin
      if (m_phase == 0 || m_phase == 3) begin
        opp = (m_phase == 0) ? m_pew : m_pns;
        if (m_time + 1 >= GREEN && (opp || n)) begin nxt = m_phase + 1; nt = 0; end
        else nt = m_time + 1;
      end else if (m_phase == 1 || m_phase == 4) begin
        if (m_time + 1 >= YELLOW) begin nxt = m_phase + 1; nt = 0; end
        else nt = m_time + 1;
      end else if (m_phase == 2 || m_phase == 5) begin
        if (m_time + 1 >= ALLRED) begin
          nt = 0;
          if (n) nxt = 6;
          else nxt = (m_phase == 2) ? 3 : 0;
        end else nt = m_time + 1;
      end else begin
        if (n) nf = ~m_flash;
        else begin nxt = 5; nt = 0; nf = 1'b0; end
      end
    end
    if (m_phase == 6) begin
      m_pns = 1'b0; m_pew = 1'b0;
    end else begin
      m_pns = (nxt == 0 && m_phase != 0) ? 1'b0 : (m_pns | r[0] | r[2]);
      m_pew = (nxt == 3 && m_phase != 3) ? 1'b0 : (m_pew | r[1] | r[3]);
    end
    m_phase = nxt; m_time = nt; m_flash = nf;
  endtask

  function automatic logic [7:0] exp_lane();
    case (m_phase)
      0: return 8'h11;
      1: return 8'h22;
      3: return 8'h44;
      4: return 8'h88;
      6: return m_flash ? 8'hFF : 8'h22;
      default: return 8'h00;
    endcase
  endfunction

  task automatic cycle(input logic t, input logic [3:0] r, input logic n);
    tick = t; req = r; night = n;
    @(posedge clk);
    model_edge(t, r, n);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick = 1'b0; req = 4'd0; night = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (laneOutput !== 8'h00 || phase !== 3'd5) begin
      errors++;
      $display("FAIL reset_state: lane=%h phase=%0d, expected lane=00 phase=5", laneOutput, phase);
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 4'd0, 1'b0);
      checks++;
      if (laneOutput !== 8'h11) begin
        errors++;
        $display("FAIL reset_ns_rest[%0d]: lane=%h expected 11", i, laneOutput);
      end
      checks++;
      if (phase !== 3'(m_phase)) begin
        errors++;
        $display("FAIL reset_phase[%0d]: phase=%0d expected %0d", i, phase, m_phase);
      end
    end
  endtask

  task automatic test_request_pulse();
    logic [7:0] exp_seq [0:3];
    exp_seq = '{8'h22, 8'h22, 8'h00, 8'h44};
    cycle(1'b0, 4'b0010, 1'b0);
    checks++;
    if (laneOutput !== 8'h11) begin
      errors++;
      $display("FAIL pulse_no_tick: lane=%h expected 11", laneOutput);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 4'd0, 1'b0);
      checks++;
      if (laneOutput !== exp_seq[i] || laneOutput !== exp_lane()) begin
        errors++;
        $display("FAIL pulse_seq[%0d]: lane=%h expected %h", i, laneOutput, exp_seq[i]);
      end
    end
    checks++;
    if (dut.pend_ew_r !== 1'b0) begin
      errors++;
      $display("FAIL pulse_pend_ew_clear: pend_ew=%b expected 0", dut.pend_ew_r);
    end
  endtask

  task automatic test_hold_req();
    logic [7:0] exp_seq [0:11];
    exp_seq = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h00,
                8'h44, 8'h44, 8'h44, 8'h44, 8'h44};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 4'b1000, 1'b0);
      checks++;
      if (laneOutput !== exp_seq[i] || laneOutput !== exp_lane()) begin
        errors++;
        $display("FAIL hold_req_seq[%0d]: lane=%h expected %h", i, laneOutput, exp_seq[i]);
      end
    end
  endtask

  task automatic test_night();
    logic [7:0] exp_seq [0:8];
    exp_seq = '{8'h22, 8'h22, 8'h00, 8'h22, 8'hFF, 8'h22, 8'hFF, 8'h00, 8'h11};
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 4'd0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, 4'd0, (i < 7) ? 1'b1 : 1'b0);
      checks++;
      if (laneOutput !== exp_seq[i] || laneOutput !== exp_lane()) begin
        errors++;
        $display("FAIL night_seq[%0d]: lane=%h expected %h", i, laneOutput, exp_seq[i]);
      end
      checks++;
      if (phase !== 3'(m_phase)) begin
        errors++;
        $display("FAIL night_phase[%0d]: phase=%0d expected %0d", i, phase, m_phase);
      end
    end
  endtask

  task automatic test_night_requests();
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 4'd0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 4'd0, 1'b1);
    checks++;
    if (phase !== 3'd6) begin
      errors++;
      $display("FAIL night_entry: phase=%0d expected 6", phase);
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1'(i % 2), 4'hF, 1'b1);
      checks++;
      if (dut.pend_ns_r !== 1'b0 || dut.pend_ew_r !== 1'b0) begin
        errors++;
        $display("FAIL night_pend_held[%0d]: pend_ns=%b pend_ew=%b expected 0 0",
                 i, dut.pend_ns_r, dut.pend_ew_r);
      end
    end
    cycle(1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 4'd0, 1'b0);
      checks++;
      if (laneOutput !== ((i == 0) ? 8'h00 : 8'h11) || laneOutput !== exp_lane()) begin
        errors++;
        $display("FAIL night_exit_rest[%0d]: lane=%h expected %h", i, laneOutput,
                 (i == 0) ? 8'h00 : 8'h11);
      end
    end
  endtask

  task automatic test_reset_midcycle();
    int guard;
    do_reset();
    guard = 0;
    while (m_phase != 4 && guard < 60) begin
      cycle(1'b1, 4'hF, 1'b0);
      guard++;
    end
    checks++;
    if (m_phase != 4 || phase !== 3'd4) begin
      errors++;
      $display("FAIL reach_ew_yellow: phase=%0d expected 4 within 60 ticks", phase);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (laneOutput !== 8'h00 || phase !== 3'd5) begin
      errors++;
      $display("FAIL async_reset: lane=%h phase=%0d expected 00 and 5", laneOutput, phase);
    end
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 4'd0, 1'b0);
      checks++;
      if (laneOutput !== 8'h11) begin
        errors++;
        $display("FAIL reset_recovery[%0d]: lane=%h expected 11", i, laneOutput);
      end
    end
  endtask

  task automatic test_random();
    logic n_v;
    logic t_v;
    logic [3:0] r_v;
    logic ns_on, ew_on;
    do_reset();
    n_v = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) n_v = ~n_v;
      t_v = ($urandom_range(0, 2) != 0);
      r_v = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      cycle(t_v, r_v, n_v);
      checks++;
      if (laneOutput !== exp_lane()) begin
        errors++;
        $display("FAIL random_lane[%0d]: lane=%h expected %h", i, laneOutput, exp_lane());
      end
      checks++;
      if (phase !== 3'(m_phase)) begin
        errors++;
        $display("FAIL random_phase[%0d]: phase=%0d expected %0d", i, phase, m_phase);
      end
      ns_on = (laneOutput[1:0] != 2'b00) || (laneOutput[5:4] != 2'b00);
      ew_on = (laneOutput[3:2] != 2'b00) || (laneOutput[7:6] != 2'b00);
      checks++;
      if (ns_on && ew_on && laneOutput !== 8'hFF) begin
        errors++;
        $display("FAIL random_safety[%0d]: lane=%h has conflicting non-red phases", i, laneOutput);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; req = 4'd0; night = 1'b0;
    model_reset();
    test_reset();
    test_request_pulse();
    test_hold_req();
    test_night();
    test_night_requests();
    test_reset_midcycle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
